// File: rtl/rot3_pkg.sv
// Shared types and helpers for the rot3 rotator checker.
package rot3_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LOCKED = 2'd1,
        ERROR  = 2'd2
    } state_t;

    localparam logic [3:0] DEF_SEED_F = 4'h5;
    localparam logic [3:0] DEF_SEED_G = 4'h8;
    localparam logic [3:0] DEF_SEED_H = 4'hC;

    // Mod-3 increment of a rotation phase.
    function automatic logic [1:0] next_phase(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/rot3_phase_match.sv
// Compares one rotator sample against the three legal rotation phases.
module rot3_phase_match #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] f_in,
    input  logic [WIDTH-1:0] g_in,
    input  logic [WIDTH-1:0] h_in,
    input  logic [WIDTH-1:0] seed_f,
    input  logic [WIDTH-1:0] seed_g,
    input  logic [WIDTH-1:0] seed_h,
    output logic [2:0]       hit
);

    logic [2:0] raw;

    assign raw[0] = (f_in == seed_f) && (g_in == seed_g) && (h_in == seed_h);
    assign raw[1] = (f_in == seed_h) && (g_in == seed_f) && (h_in == seed_g);
    assign raw[2] = (f_in == seed_g) && (g_in == seed_h) && (h_in == seed_f);

    // Priority-encode to one-hot so degenerate seed sets still give a single phase.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        hit = 3'b000;
        if (raw[0])      hit = 3'b001;
        else if (raw[1]) hit = 3'b010;
        else if (raw[2]) hit = 3'b100;
    end

endmodule

// File: rtl/rot3_checker.sv
// Receive-side checker: locks onto the rotator phase, counts legal steps,
// and flags illegal transitions once locked.
module rot3_checker
    import rot3_pkg::*;
#(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] SEED_F   = WIDTH'(DEF_SEED_F),
    parameter logic [WIDTH-1:0] SEED_G   = WIDTH'(DEF_SEED_G),
    parameter logic [WIDTH-1:0] SEED_H   = WIDTH'(DEF_SEED_H),
    parameter int               LOCK_CNT = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] f_in,
    input  logic [WIDTH-1:0] g_in,
    input  logic [WIDTH-1:0] h_in,
    input  logic             err_clear,
    output logic             locked,
    output logic [1:0]       phase,
    output logic             mismatch,
    output logic             err_sticky,
    output logic [15:0]      step_count
);

    localparam int RUN_W = $clog2(LOCK_CNT + 1);

    state_t           state;
    logic [RUN_W-1:0] run;
    logic [1:0]       run_phase;
    logic [2:0]       hit;
    logic             legal;
    logic [1:0]       hit_phase;
    logic [RUN_W-1:0] run_next;

    rot3_phase_match #(
        .WIDTH (WIDTH)
    ) u_match (
        .f_in   (f_in),
        .g_in   (g_in),
        .h_in   (h_in),
        .seed_f (SEED_F),
        .seed_g (SEED_G),
        .seed_h (SEED_H),
        .hit    (hit)
    );

    assign legal = |hit;

    // Encode the one-hot match into a phase index.
    always_comb begin
        hit_phase = 2'd0;
        if (hit[1])      hit_phase = 2'd1;
        else if (hit[2]) hit_phase = 2'd2;
    end

    // Run length the SEARCH state would hold after this sample.
    always_comb begin
        run_next = '0;
        if (legal) begin
            if (run != '0 && hit_phase == next_phase(run_phase))
                run_next = run + RUN_W'(1);
            else
                run_next = RUN_W'(1);
        end
    end

    // Checker FSM with registered outputs; a mismatch set beats err_clear.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!reset_n) begin
            state      <= SEARCH;
            run        <= '0;
            run_phase  <= 2'd0;
            locked     <= 1'b0;
            phase      <= 2'd0;
            mismatch   <= 1'b0;
            err_sticky <= 1'b0;
            step_count <= 16'd0;
        end else begin
            mismatch <= 1'b0;
            if (err_clear) err_sticky <= 1'b0;
            unique case (state)
                SEARCH: begin
                    if (in_valid) begin
                        if (legal && run_next == RUN_W'(LOCK_CNT)) begin
                            state      <= LOCKED;
                            locked     <= 1'b1;
                            phase      <= hit_phase;
                            step_count <= 16'd0;
                            run        <= '0;
                        end else begin
                            run       <= run_next;
                            run_phase <= hit_phase;
                        end
                    end
                end
                LOCKED: begin
                    if (in_valid) begin
                        if (hit[next_phase(phase)]) begin
                            phase <= next_phase(phase);
                            if (step_count != 16'hFFFF) step_count <= step_count + 16'd1;
                        end else if (hit[0]) begin
                            phase      <= 2'd0;
                            step_count <= 16'd0;
                        end else begin
                            mismatch   <= 1'b1;
                            err_sticky <= 1'b1;
                            state      <= ERROR;
                            locked     <= 1'b0;
                            phase      <= 2'd0;
                        end
                    end
                end
                ERROR: begin
                    if (err_clear) begin
                        state <= SEARCH;
                        run   <= '0;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

endmodule

// File: tb/tb_rot3_checker.sv
// Directed self-checking bench for rot3_checker (LOCK_CNT=3 plus a LOCK_CNT=1 instance).
module tb_rot3_checker;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  f_in = 4'h0, g_in = 4'h0, h_in = 4'h0;
    logic        err_clear = 1'b0;

    logic        locked, mismatch, err_sticky;
    logic [1:0]  phase;
    logic [15:0] step_count;
    logic        locked1, mismatch1, err_sticky1;
    logic [1:0]  phase1;
    logic [15:0] step_count1;

    int checks = 0;
    int failures = 0;

    // Phase triples for seeds 5/8/C.
    logic [3:0] pf [3] = '{4'h5, 4'hC, 4'h8};
    logic [3:0] pg [3] = '{4'h8, 4'h5, 4'hC};
    logic [3:0] ph [3] = '{4'hC, 4'h8, 4'h5};

    always #5 clk = ~clk;

    rot3_checker #(.WIDTH(4), .LOCK_CNT(3)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid),
        .f_in(f_in), .g_in(g_in), .h_in(h_in), .err_clear(err_clear),
        .locked(locked), .phase(phase), .mismatch(mismatch),
        .err_sticky(err_sticky), .step_count(step_count)
    );

    rot3_checker #(.WIDTH(4), .LOCK_CNT(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid),
        .f_in(f_in), .g_in(g_in), .h_in(h_in), .err_clear(err_clear),
        .locked(locked1), .phase(phase1), .mismatch(mismatch1),
        .err_sticky(err_sticky1), .step_count(step_count1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] f, input logic [3:0] g,
                         input logic [3:0] h, input logic clr);
        @(negedge clk);
        in_valid  = v;
        f_in      = f;
        g_in      = g;
        h_in      = h;
        err_clear = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int p);
        drive(1'b1, pf[p], pg[p], ph[p], 1'b0);
    endtask

    initial begin
        // Reset overrides a legal sample.
        reset_n = 1'b0;
        feed(0);
        feed(0);
        check("rst_locked", locked, 1'b0);
        check("rst_phase", phase, 2'd0);
        check("rst_mismatch", mismatch, 1'b0);
        check("rst_err", err_sticky, 1'b0);
        check("rst_step", step_count, 16'd0);
        check("rst_locked1", locked1, 1'b0);

        // Lock acquisition.
        reset_n = 1'b1;
        feed(0);
        check("acq1_locked", locked, 1'b0);
        check("lc1_locked", locked1, 1'b1);
        check("lc1_phase", phase1, 2'd0);
        feed(1);
        check("acq2_locked", locked, 1'b0);
        feed(2);
        check("acq3_locked", locked, 1'b1);
        check("acq3_phase", phase, 2'd2);
        check("acq3_step", step_count, 16'd0);
        feed(0);
        check("step1_phase", phase, 2'd0);
        check("step1_count", step_count, 16'd1);
        feed(1);
        check("step2_phase", phase, 2'd1);
        check("step2_count", step_count, 16'd2);

        // Rotator reset seen while at phase 1: resync.
        feed(0);
        check("resync_phase", phase, 2'd0);
        check("resync_step", step_count, 16'd0);
        check("resync_mismatch", mismatch, 1'b0);
        check("resync_locked", locked, 1'b1);
        feed(1);
        feed(2);
        feed(0);
        check("pre_err_step", step_count, 16'd3);

        // Illegal sample while locked.
        drive(1'b1, 4'h5, 4'h5, 4'h5, 1'b0);
        check("err_mismatch", mismatch, 1'b1);
        check("err_sticky", err_sticky, 1'b1);
        check("err_locked", locked, 1'b0);
        check("err_phase", phase, 2'd0);
        check("err_step_frozen", step_count, 16'd3);
        feed(1);
        check("err_no_pulse1", mismatch, 1'b0);
        check("err_step_hold", step_count, 16'd3);
        drive(1'b1, 4'h5, 4'h5, 4'h5, 1'b0);
        check("err_no_pulse2", mismatch, 1'b0);
        check("err_still_sticky", err_sticky, 1'b1);
        drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        check("clr_err", err_sticky, 1'b0);
        check("clr_locked", locked, 1'b0);

        // Lock with stalls carrying garbage and P0 data.
        feed(0);
        drive(1'b0, 4'h3, 4'h3, 4'h3, 1'b0);
        feed(1);
        drive(1'b0, 4'h5, 4'h8, 4'hC, 1'b0);
        drive(1'b0, 4'hF, 4'h0, 4'h1, 1'b0);
        check("stall_not_yet", locked, 1'b0);
        feed(2);
        check("stall_locked", locked, 1'b1);
        check("stall_phase", phase, 2'd2);
        check("stall_step", step_count, 16'd0);

        // Repeat of current phase together with err_clear: set wins.
        drive(1'b1, pf[2], pg[2], ph[2], 1'b1);
        check("both_mismatch", mismatch, 1'b1);
        check("both_err", err_sticky, 1'b1);
        check("both_locked", locked, 1'b0);
        feed(0);
        check("both_in_error", locked, 1'b0);
        drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        check("both_clr", err_sticky, 1'b0);

        // Relock, err_clear in LOCKED leaves state, then reset mid-lock.
        feed(0);
        feed(1);
        feed(2);
        check("relock", locked, 1'b1);
        drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
        check("clr_in_lock", locked, 1'b1);
        feed(0);
        check("relock_step", step_count, 16'd1);
        reset_n = 1'b0;
        feed(1);
        check("midrst_locked", locked, 1'b0);
        check("midrst_phase", phase, 2'd0);
        check("midrst_step", step_count, 16'd0);
        check("midrst_err", err_sticky, 1'b0);
        reset_n = 1'b1;

        // Illegal sample in SEARCH clears the run.
        feed(0);
        feed(1);
        drive(1'b1, 4'h1, 4'h2, 4'h3, 1'b0);
        check("search_no_mismatch", mismatch, 1'b0);
        feed(2);
        check("runclr_not_locked", locked, 1'b0);
        feed(0);
        check("runclr_not_locked2", locked, 1'b0);
        feed(1);
        check("runclr_locked", locked, 1'b1);
        check("runclr_phase", phase, 2'd1);

        // Saturation of step_count.
        for (int k = 1; k <= 65534; k++) feed((k + 1) % 3);
        check("sat_fffe", step_count, 16'hFFFE);
        feed((65535 + 1) % 3);
        check("sat_ffff", step_count, 16'hFFFF);
        feed((65536 + 1) % 3);
        feed((65537 + 1) % 3);
        check("sat_hold", step_count, 16'hFFFF);
        check("sat_locked", locked, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rot3_checker.md
# rot3_checker

Receive-side checker for the three-register rotator (f, g, h; reset seed 5/8/C; each step (f,g,h) -> (h,f,g)). It samples the rotator's outputs, locks onto the rotation phase, counts legal steps and flags any illegal transition. It sits beside the rotator in the same clock domain, as a self-check block in the demo design and the bench.

## Interface
Parameters:
- WIDTH, 4: width of each of f/g/h.
- SEED_F, 4'h5: rotator reset value of f.
- SEED_G, 4'h8: rotator reset value of g.
- SEED_H, 4'hC: rotator reset value of h.
- LOCK_CNT, 3: consecutive legal samples required to declare lock (>=1).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  f_in/g_in/h_in hold a rotator sample this cycle.
- f_in, g_in, h_in  input  WIDTH each  observed rotator outputs.
- err_clear  input  1  clears err_sticky and leaves ERROR.
- locked  output  1  high in LOCKED.
- phase  output  2  current phase 0..2 when locked, else 0.
- mismatch  output  1  one-cycle pulse on an illegal sample while LOCKED.
- err_sticky  output  1  set by mismatch, held until err_clear.
- step_count  output  16  legal steps since lock/resync, saturating at 16'hFFFF.

## Operation
- Phase triples:
  - P0 = (SEED_F, SEED_G, SEED_H)
  - P1 = (SEED_H, SEED_F, SEED_G)
  - P2 = (SEED_G, SEED_H, SEED_F)
- Next phase is (p+1) mod 3.
- A match is an exact equality on all three fields. A sample matching no phase is "illegal". Cycles with in_valid=0 are ignored entirely (stall).
- FSM states: SEARCH, LOCKED, ERROR.
- SEARCH:
  - A legal sample with run=0 records its phase and sets run=1.
  - A legal sample equal to the expected next phase increments run.
  - A legal sample not equal to the expected phase restarts run=1 at that phase.
  - An illegal sample clears run to 0.
  - When run reaches LOCK_CNT, go to LOCKED with phase = the last matched phase and step_count=0.
  - No mismatch is raised in SEARCH.
- LOCKED:
  - Sample equals the next phase: advance phase, step_count+1 (saturating).
  - Sample equals P0 but is not the expected phase (rotator reset): resync with phase=0, step_count=0, no error, stay in LOCKED.
  - Anything else, including a repeat of the current phase: mismatch pulse, err_sticky=1, go to ERROR.
- ERROR:
  - locked=0, phase=0, and the step_count value is frozen. Samples are ignored and no further mismatch pulses are raised.
  - err_clear goes to SEARCH with run=0.
- err_clear in SEARCH/LOCKED clears err_sticky only; the state is unchanged.
- A mismatch and err_clear in the same cycle: the set wins, err_sticky stays 1, and the state goes to ERROR.
- The LOCK_CNT=1 boundary: the first legal sample locks immediately.

## Timing
- All outputs are registered and update on the clk edge that samples the input: one-cycle latency from the sample to the locked/phase/mismatch/step_count change.
- Reset (reset_n=0 at an edge) gives state=SEARCH, run=0, locked=0, phase=0, mismatch=0, err_sticky=0, step_count=0. It overrides all other inputs.
- Reset mid-lock or mid-error drops to SEARCH on that edge.
- mismatch is high for exactly one cycle per ERROR entry.
- Back-to-back valid samples every cycle are sustained; there is no throughput limit.

## Structure
- Package rot3_pkg holds:
  - the state enum (SEARCH, LOCKED, ERROR);
  - the default seed localparams;
  - the function next_phase(p) (mod-3 increment).
- Sub-module rot3_phase_match: combinational, takes the three fields and seeds, and returns a one-hot hit[2:0] (all zero means illegal). It is instantiated once in rot3_checker.
- The FSM, run counter, phase register, step counter and error flag live in rot3_checker.

## Test plan
- Reset, then feed P0,P1,P2,P0 on consecutive valid cycles with LOCK_CNT=3 -> locked=1 after the 3rd sample's edge, phase=2. The 4th sample gives phase=0, step_count=1.
- While locked at phase 1, feed (5,8,C) -> resync: phase=0, step_count=0, mismatch=0, locked stays 1.
- While locked at phase 0, feed (5,5,5) -> mismatch=1 for one cycle, err_sticky=1, locked=0. Further samples give no more pulses. Assert err_clear -> SEARCH, err_sticky=0.
- Interleave in_valid=0 cycles and garbage data during the stalls within a legal P0,P1,P2 sequence -> lock still achieved with identical outputs.
- Mismatch and err_clear in the same cycle -> err_sticky=1 and state ERROR. Drop reset_n mid-lock -> all outputs at reset values on the next edge.
- Preload step_count near saturation (force or long run) -> it holds at 16'hFFFF without wrapping.
